// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall unit beside ID/EX.
// Optional FWD_PERF_CNT_EN adds stall/forward performance counters.
module fwd_hazard_unit #(
  parameter int NREAD    = 2,
  parameter int AW       = 5,
  parameter int NSTAGE   = 2,
  parameter int LOAD_LAT = 1,
  localparam int SW      = $clog2(NSTAGE + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [NREAD*AW-1:0] id_rs,
  input  logic [NREAD-1:0]    id_rs_used,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_regwrite,
  input  logic                id_is_load,
  input  logic                hold,
  input  logic                flush,
  output logic                stall,
  output logic [NREAD*SW-1:0] fwd_sel
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_fwd_cnt
`endif
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          rw;
    logic          ld;
  } ent_t;

  ent_t                ent [NSTAGE+1];
  logic [NREAD*AW-1:0] ex_rs;
  logic [NREAD-1:0]    ex_rs_used;

  function automatic logic match(
    input logic [AW-1:0] rs,
    input ent_t          e
  );
    return e.valid & e.rw & (e.rd != '0) & (rs == e.rd);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= NSTAGE; k++) ent[k] <= '0;
      ex_rs      <= '0;
      ex_rs_used <= '0;
    end else begin
      if (!hold) begin
        for (int k = 1; k <= NSTAGE; k++) ent[k] <= ent[k-1];
      end
      if (flush || (!hold && stall)) begin
        ent[0]     <= '0;
        ex_rs_used <= '0;
      end else if (!hold) begin
        ent[0]     <= '{id_valid, id_rd, id_regwrite, id_is_load};
        ex_rs      <= id_rs;
        ex_rs_used <= id_rs_used & {NREAD{id_valid}};
      end
    end
  end

  // Youngest producer wins; an unforwardable youngest load yields regfile.
  always_comb begin
    logic hit;
    fwd_sel = '0;
    hit     = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      hit = 1'b0;
      for (int k = 1; k <= NSTAGE; k++) begin
        if (!hit && ex_rs_used[p] && match(ex_rs[p*AW +: AW], ent[k])) begin
          hit = 1'b1;
          if (!(ent[k].ld && k <= LOAD_LAT)) fwd_sel[p*SW +: SW] = SW'(k);
        end
      end
    end
  end

  // A younger match of any kind shadows an older in-flight load.
  always_comb begin
    logic blk;
    logic st;
    st  = 1'b0;
    blk = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      blk = 1'b0;
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (match(id_rs[p*AW +: AW], ent[j])) begin
          if (ent[j].ld && !blk && id_rs_used[p]) st = 1'b1;
          blk = 1'b1;
        end
      end
    end
    stall = st & id_valid;
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else if (!hold) begin
      if (stall && !flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (|fwd_sel)        perf_fwd_cnt   <= perf_fwd_cnt + 32'd1;
    end
  end
`else
  // counters and their ports are absent in this build
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two configurations against a producer-search model.
// Directed spec scenarios followed by randomized traffic.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       hold;
  logic       flush;
  logic       stall_a, stall_b;
  logic [3:0] fwd_a, fwd_b;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] pst_a, pfw_a, pst_b, pfw_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NREAD(2), .AW(5), .NSTAGE(2), .LOAD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .stall(stall_a), .fwd_sel(fwd_a)
`ifdef FWD_PERF_CNT_EN
    , .perf_stall_cnt(pst_a), .perf_fwd_cnt(pfw_a)
`endif
  );

  fwd_hazard_unit #(.NREAD(2), .AW(5), .NSTAGE(3), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .stall(stall_b), .fwd_sel(fwd_b)
`ifdef FWD_PERF_CNT_EN
    , .perf_stall_cnt(pst_b), .perf_fwd_cnt(pfw_b)
`endif
  );

  // Model: per config, the instructions in EX and behind it, youngest first.
  typedef struct { bit v; bit [4:0] rd; bit rw; bit ld; } me_t;
  me_t         m [2][4];
  bit [4:0]    mrs [2][2];
  bit          mused [2][2];
  int unsigned mcs [2];
  int unsigned mcf [2];

  function automatic int nsf(int d); return d ? 3 : 2; endfunction
  function automatic int llf(int d); return d ? 2 : 1; endfunction

  function automatic int youngest(int d, bit [4:0] r, int lo);
    for (int k = lo; k <= nsf(d); k++)
      if (m[d][k].v && m[d][k].rw && m[d][k].rd != 0 && m[d][k].rd == r)
        return k;
    return -1;
  endfunction

  function automatic bit exp_stall(int d);
    bit s = 0;
    if (!id_valid) return 0;
    for (int p = 0; p < 2; p++) begin
      if (id_rs_used[p]) begin
        int j = youngest(d, id_rs[p*5 +: 5], 0);
        if (j >= 0 && j < llf(d) && m[d][j].ld) s = 1;
      end
    end
    return s;
  endfunction

  function automatic logic [3:0] exp_fwd(int d);
    logic [3:0] f = '0;
    for (int p = 0; p < 2; p++) begin
      if (mused[d][p]) begin
        int k = youngest(d, mrs[d][p], 1);
        if (k > 0 && !(m[d][k].ld && k <= llf(d))) f[p*2 +: 2] = 2'(k);
      end
    end
    return f;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) m[d][k] = '{default: 0};
      mused[d][0] = 0; mused[d][1] = 0;
      mrs[d][0] = 0; mrs[d][1] = 0;
      mcs[d] = 0; mcf[d] = 0;
    end
  endtask

  task automatic mstep(int d);
    bit st;
    logic [3:0] fw;
    st = exp_stall(d);
    fw = exp_fwd(d);
    if (!hold && !flush && st) mcs[d]++;
    if (!hold && fw != 0) mcf[d]++;
    if (!hold)
      for (int k = nsf(d); k >= 1; k--) m[d][k] = m[d][k-1];
    if (flush || (!hold && st)) begin
      m[d][0] = '{default: 0};
      mused[d][0] = 0; mused[d][1] = 0;
    end else if (!hold) begin
      m[d][0] = '{id_valid, id_rd, id_regwrite, id_is_load};
      mrs[d][0] = id_rs[4:0]; mrs[d][1] = id_rs[9:5];
      mused[d][0] = id_rs_used[0] & id_valid;
      mused[d][1] = id_rs_used[1] & id_valid;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #5;
    chk("stall_a", {31'd0, stall_a}, {31'd0, exp_stall(0)});
    chk("stall_b", {31'd0, stall_b}, {31'd0, exp_stall(1)});
    chk("fwd_a", {28'd0, fwd_a}, {28'd0, exp_fwd(0)});
    chk("fwd_b", {28'd0, fwd_b}, {28'd0, exp_fwd(1)});
`ifdef FWD_PERF_CNT_EN
    chk("pst_a", pst_a, mcs[0]);
    chk("pfw_a", pfw_a, mcf[0]);
    chk("pst_b", pst_b, mcs[1]);
    chk("pfw_b", pfw_b, mcf[1]);
`endif
  endtask

  task automatic advance();
    mstep(0);
    mstep(1);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic ins(bit v, bit [4:0] r0, bit [4:0] r1, bit [1:0] u,
                     bit [4:0] rd, bit rw, bit ld);
    id_valid = v; id_rs = {r1, r0}; id_rs_used = u;
    id_rd = rd; id_regwrite = rw; id_is_load = ld;
    hold = 0; flush = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      ins(0, 0, 0, 0, 0, 0, 0);
      cyc();
    end
  endtask

  initial begin
    rst_n = 0;
    ins(1, 5, 7, 3, 5, 1, 1);
    mreset();
    #1;
    chk("rst_stall", {31'd0, stall_a}, 32'd0);
    chk("rst_fwd_a", {28'd0, fwd_a}, 32'd0);
    chk("rst_fwd_b", {28'd0, fwd_b}, 32'd0);
    #11 rst_n = 1;
    ins(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // add x5; dependant on port0 sees MEM
    ins(1, 1, 2, 3, 5, 1, 0); cyc();
    ins(1, 5, 3, 3, 6, 1, 0); cyc();
    ins(0, 0, 0, 0, 0, 0, 0); settle();
    chk("fwd_mem_a", {28'd0, fwd_a}, 32'h1);
    chk("fwd_mem_b", {28'd0, fwd_b}, 32'h1);

    // asynchronous reset with ent[1] valid
    #1 rst_n = 0;
    mreset();
    #1;
    chk("arst_fwd_a", {28'd0, fwd_a}, 32'd0);
    chk("arst_fwd_b", {28'd0, fwd_b}, 32'd0);
    chk("arst_stall", {31'd0, stall_a}, 32'd0);
    #1 rst_n = 1;
    mstep(0); mstep(1);
    @(posedge clk);
    #1;

    // one bubble between producer and consumer -> WB
    ins(1, 1, 2, 3, 5, 1, 0); cyc();
    ins(0, 0, 0, 0, 0, 0, 0); cyc();
    ins(1, 5, 3, 1, 6, 1, 0); cyc();
    ins(0, 0, 0, 0, 0, 0, 0); settle();
    chk("fwd_wb", {28'd0, fwd_a}, 32'h2);
    advance();

    // MEM and WB both write x5 -> youngest on port1
    idle(3);
    ins(1, 1, 2, 3, 5, 1, 0); cyc();
    ins(1, 1, 2, 3, 5, 1, 0); cyc();
    ins(1, 0, 5, 2, 6, 1, 0); cyc();
    ins(0, 0, 0, 0, 0, 0, 0); settle();
    chk("fwd_young", {28'd0, fwd_a}, 32'h4);
    advance();

    // x0 writer never forwards
    idle(3);
    ins(1, 1, 2, 3, 0, 1, 0); cyc();
    ins(1, 0, 0, 3, 6, 1, 0); cyc();
    ins(0, 0, 0, 0, 0, 0, 0); settle();
    chk("fwd_x0", {28'd0, fwd_a}, 32'h0);
    advance();

    // load-use: lw x7 then add using x7 on port1
    idle(3);
    ins(1, 1, 2, 3, 7, 1, 1); cyc();
    ins(1, 3, 7, 3, 8, 1, 0); settle();
    chk("lu_st1_a", {31'd0, stall_a}, 32'd1);
    chk("lu_st1_b", {31'd0, stall_b}, 32'd1);
    advance(); settle();
    chk("lu_st2_a", {31'd0, stall_a}, 32'd0);
    chk("lu_st2_b", {31'd0, stall_b}, 32'd1);
    advance(); settle();
    chk("lu_fwd_a", {28'd0, fwd_a}, 32'h8);
    chk("lu_st3_b", {31'd0, stall_b}, 32'd0);
    advance();
    ins(0, 0, 0, 0, 0, 0, 0); settle();
    chk("lu_fwd_b", {28'd0, fwd_b}, 32'hC);
    advance();

    // flush kills the load entering EX
    idle(4);
    ins(1, 1, 2, 3, 7, 1, 1); flush = 1; cyc();
    ins(1, 3, 7, 3, 8, 1, 0); settle();
    chk("fl_st_a", {31'd0, stall_a}, 32'd0);
    chk("fl_st_b", {31'd0, stall_b}, 32'd0);
    advance();
    ins(0, 0, 0, 0, 0, 0, 0); settle();
    chk("fl_fwd_a", {28'd0, fwd_a}, 32'h0);
    advance();

    // hold freezes forwarding state
    idle(4);
    ins(1, 1, 2, 3, 5, 1, 0); cyc();
    ins(1, 5, 3, 3, 6, 1, 0); cyc();
    ins(1, 5, 5, 3, 9, 1, 0); hold = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_fwd", {28'd0, fwd_a}, 32'h1);
      advance();
    end
    hold = 0;
    cyc();

    for (int i = 0; i < 500; i++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used  = 2'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 7));
      id_regwrite = ($urandom_range(0, 3) != 0);
      id_is_load  = ($urandom_range(0, 2) == 0);
      hold        = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
